iq_stream_packer: RTL and testbench
===================================

# iq_stream_packer

Downstream stage of `overlay_top_wrapper`. It consumes the four 16-bit I/Q output lanes (I0, Q0, I1, Q1) and packs each aligned sample set into one 64-bit word. Words are buffered in a small FIFO and presented on an AXI4-Stream master toward the DMA. The block frames the stream into fixed-length packets with `tlast`, accepts new packets only while enabled, and counts samples dropped on overflow.

## Interface
- `FIFO_DEPTH`, default 16: FIFO entries; must be a power of 2 and at least 4.
- `PKT_LEN`, default 256: beats per packet; must be at least 2.
- `CNT_W`, default 16: width of the overflow counter.
- `i_clk`  in  1  single clock for all logic.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_I0_data`, `i_Q0_data`, `i_I1_data`, `i_Q1_data`  in  16 each  overlay output lanes.
- `i_I0_valid`, `i_Q0_valid`, `i_I1_valid`, `i_Q1_valid`  in  1 each  per-lane valid strobes.
- `i_enable`  in  1  capture enable; it is honoured only at packet boundaries.
- `o_m_axis_tdata`  out  64  packed word `{Q1, I1, Q0, I0}`, with I0 in bits [15:0].
- `o_m_axis_tvalid`  out  1  FIFO not empty.
- `i_m_axis_tready`  in  1  sink ready.
- `o_m_axis_tlast`  out  1  last beat of a packet.
- `o_fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `o_overflow_cnt`  out  CNT_W  number of strobes dropped because the FIFO was full; saturates.
- `o_active`  out  1  high when the FSM is not in IDLE.

## Operation
- **Strobe.** A strobe occurs when all four valids are high in the same cycle. If any valid is low, nothing is captured and no counter changes.
- **FSM states: IDLE and RUN.**
  - IDLE → RUN when `i_enable`=1. The beat counter is cleared to 0 on entry to RUN.
  - IDLE ignores strobes. An ignored strobe is not an overflow.
  - RUN → IDLE when `i_enable`=0 and the beat counter is 0 with no push this cycle.
  - RUN → IDLE when `i_enable`=0 and the push this cycle is the tlast beat.
  - If `i_enable` drops mid-packet, RUN keeps accepting strobes until the packet completes. Packets therefore always end with `tlast`.
- **Push.** A push happens on a strobe in RUN when the FIFO is not full, or when it is full but a pop occurs in the same cycle.
  - The pushed entry is 65 bits: `{last, Q1, I1, Q0, I0}`.
  - `last` = (beat counter == PKT_LEN-1).
  - The beat counter increments on each push and wraps to 0 after PKT_LEN-1.
- **Overflow.** A strobe in RUN that cannot be pushed is dropped.
  - `o_overflow_cnt` increments, saturating at 2^CNT_W-1.
  - The beat counter does not advance on a dropped strobe.
  - `o_overflow_cnt` is cleared only by reset.
- **Output.** The FIFO is first-word-fall-through.
  - `tdata` and `tlast` come from the head entry.
  - A pop occurs on `tvalid & tready`.
  - While `tvalid`=1 and `tready`=0, `tdata` and `tlast` stay stable.
- **Level.** `o_fifo_level` = pushes − pops. On a simultaneous push and pop the level is unchanged.

## Timing
- **Reset.** While `i_rst_n`=0, the following hold, asynchronously:
  - FSM in IDLE;
  - FIFO empty;
  - beat counter 0;
  - all outputs 0: `tdata`, `tvalid`, `tlast`, `o_fifo_level`, `o_overflow_cnt`, `o_active`.
- **Reset mid-operation.** Assertion discards the FIFO contents and any partial packet. After deassertion the block starts in IDLE.
- **Latency.** A strobe at edge N into an empty FIFO gives `tvalid`=1 with that word after edge N (one cycle).
- **Throughput.** One push and one pop per cycle are sustained, including back-to-back strobes.
- **`o_active`.** Registered; it reflects the FSM state after each edge.
- **IDLE → RUN.** `i_enable` seen high at edge N means a strobe at edge N+1 is the first one accepted.

## Test plan
- **Reset.** Hold `i_rst_n`=0 and toggle all valids → every output stays 0. Assert reset mid-packet with level 5 → level 0 and `tvalid` 0 immediately; the next packet starts at beat 0.
- **Basic packet.** PKT_LEN=4, `tready`=1, `i_enable`=1. Send 4 strobes with I0=1..4, Q0=0x10..0x13, I1=0x20..0x23, Q1=0x30..0x33 → 4 beats, first `tdata`=0x0030_0020_0010_0001, `tlast` on beat 4 only, each beat one cycle after its strobe.
- **Backpressure and overflow.** DEPTH=16, PKT_LEN=4, `tready`=0, 20 strobes → level 16, `o_overflow_cnt`=4. Then `tready`=1 → 16 beats in order, `tlast` on beats 4, 8, 12 and 16.
- **Full with simultaneous pop.** FIFO full, strobe and pop in the same cycle → strobe accepted, level stays 16, overflow count unchanged.
- **Enable drop mid-packet.** PKT_LEN=4, drop `i_enable` after 2 beats → 2 more strobes accepted, `tlast` on the 4th, `o_active`=0, later strobes ignored with the overflow count still 0.
- **Partial valids.** Only I0/Q0 valid, or the valids staggered by one cycle → no push, level and counters unchanged.

Source files
------------

// File: rtl/iq_stream_packer.sv
// Packs aligned I0/Q0/I1/Q1 sample sets into 64-bit words, buffers them in a
// first-word-fall-through FIFO and frames them as fixed-length AXI4-Stream packets.
module iq_stream_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int PKT_LEN    = 256,
  parameter int CNT_W      = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [15:0]                   i_I0_data,
  input  logic [15:0]                   i_Q0_data,
  input  logic [15:0]                   i_I1_data,
  input  logic [15:0]                   i_Q1_data,
  input  logic                          i_I0_valid,
  input  logic                          i_Q0_valid,
  input  logic                          i_I1_valid,
  input  logic                          i_Q1_valid,
  input  logic                          i_enable,
  output logic [63:0]                   o_m_axis_tdata,
  output logic                          o_m_axis_tvalid,
  input  logic                          i_m_axis_tready,
  output logic                          o_m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic [CNT_W-1:0]              o_overflow_cnt,
  output logic                          o_active
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);
  localparam logic [AW:0]   FULL_LVL  = FIFO_DEPTH[AW:0];

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [64:0]     mem [FIFO_DEPTH];
  logic [64:0]     head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     level;
  logic [BW-1:0]   beat;
  logic [CNT_W-1:0] ovf_cnt;
  logic            strobe;
  logic            empty;
  logic            full;
  logic            pop;
  logic            push;
  logic            drop;
  logic            is_last;

  assign strobe  = i_I0_valid & i_Q0_valid & i_I1_valid & i_Q1_valid;
  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  assign pop     = !empty && i_m_axis_tready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push    = (state == RUN) && strobe && (!full || pop);
  assign drop    = (state == RUN) && strobe && !push;
  assign is_last = (beat == LAST_BEAT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Leaving RUN waits for a packet boundary so every packet ends with tlast.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_enable) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!i_enable && ((beat == '0 && !push) || (push && is_last))) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= {is_last, i_Q1_data, i_I1_data, i_Q0_data, i_I0_data};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      beat <= '0;
    end else if (state == IDLE) begin
      beat <= '0;
    end else if (push) begin
      beat <= is_last ? '0 : beat + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_cnt <= '0;
    end else if (drop && ovf_cnt != '1) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign head            = empty ? '0 : mem[rd_ptr];
  assign o_m_axis_tdata  = head[63:0];
  assign o_m_axis_tlast  = head[64];
  assign o_m_axis_tvalid = !empty;
  assign o_fifo_level    = level;
  assign o_overflow_cnt  = ovf_cnt;
  assign o_active        = (state == RUN);

endmodule

// File: tb/tb_iq_stream_packer.sv
// Self-checking bench for iq_stream_packer against a queue-based packet model.
module tb_iq_stream_packer;

  localparam int DEPTH = 16;
  localparam int PLEN  = 4;
  localparam int CW    = 4;
  localparam logic [3:0] ALL = 4'hF;

  logic        clk;
  logic        rst_n;
  logic [15:0] i0_d, q0_d, i1_d, q1_d;
  logic        i0_v, q0_v, i1_v, q1_v;
  logic        enable;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic [4:0]  level;
  logic [CW-1:0] ovf_cnt;
  logic        active;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [64:0] q[$];
  logic        running;
  int          beats;
  int          ovf;

  logic [75:0] obs;
  assign obs = {active, ovf_cnt, level, tvalid, tlast, tdata};

  iq_stream_packer #(
    .FIFO_DEPTH(DEPTH),
    .PKT_LEN   (PLEN),
    .CNT_W     (CW)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_I0_data      (i0_d),
    .i_Q0_data      (q0_d),
    .i_I1_data      (i1_d),
    .i_Q1_data      (q1_d),
    .i_I0_valid     (i0_v),
    .i_Q0_valid     (q0_v),
    .i_I1_valid     (i1_v),
    .i_Q1_valid     (q1_v),
    .i_enable       (enable),
    .o_m_axis_tdata (tdata),
    .o_m_axis_tvalid(tvalid),
    .i_m_axis_tready(tready),
    .o_m_axis_tlast (tlast),
    .o_fifo_level   (level),
    .o_overflow_cnt (ovf_cnt),
    .o_active       (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [75:0] expv();
    logic [64:0] h;
    h = (q.size() != 0) ? q[0] : '0;
    return {running, 4'(ovf), 5'(q.size()), q.size() != 0, h[64], h[63:0]};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic model_clear();
    q.delete();
    running = 1'b0;
    beats   = 0;
    ovf     = 0;
  endtask

  // Drives one cycle of inputs, advances one clock and steps the model.
  task automatic cycle(input logic [3:0] v, input logic en, input logic rdy,
                       input logic [63:0] d);
    bit strobe, pop, push, drop, nxt;
    {q1_v, i1_v, q0_v, i0_v} = v;
    {q1_d, i1_d, q0_d, i0_d} = d;
    enable = en;
    tready = rdy;
    if (!rst_n) begin
      model_clear();
      @(posedge clk);
      #1;
      return;
    end
    strobe = (v == ALL);
    pop    = (q.size() != 0) && rdy;
    push   = running && strobe && (q.size() < DEPTH || pop);
    drop   = running && strobe && !push;
    if (!running) nxt = en;
    else nxt = !(!en && ((beats == 0 && !push) || (push && beats == PLEN - 1)));
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back({beats == PLEN - 1, d});
      beats = (beats + 1) % PLEN;
    end
    if (drop && ovf < (1 << CW) - 1) ovf++;
    running = nxt;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle(4'h0, 1'b0, 1'b0, '0);
    rst_n = 1'b1;
    cycle(4'h0, 1'b1, 1'b1, '0);
  endtask

  task automatic test_reset();
    logic [63:0] d;
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle(4'($urandom), 1'b1, 1'($urandom), rnd64());
      checks++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL reset_hold i=%0d got %h exp 0", i, obs);
      end
    end
    rst_n = 1'b1;
    cycle(4'h0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) cycle(ALL, 1'b1, 1'b0, rnd64());
    checks++;
    if (level !== 5'd5 || obs !== expv()) begin
      errors++;
      $display("FAIL reset_prefill got level %0d obs %h exp level 5 obs %h", level, obs, expv());
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_async got %h exp 0", obs);
    end
    model_clear();
    cycle(ALL, 1'b1, 1'b1, rnd64());
    rst_n = 1'b1;
    cycle(4'h0, 1'b1, 1'b1, '0);
    for (int k = 0; k < PLEN; k++) begin
      d = rnd64();
      cycle(ALL, 1'b1, 1'b1, d);
      checks++;
      if (obs !== expv() || tdata !== d || tlast !== (k == PLEN - 1)) begin
        errors++;
        $display("FAIL reset_restart k=%0d got %h exp %h", k, obs, expv());
      end
    end
  endtask

  task automatic test_basic();
    logic [63:0] d;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      d = {16'(16'h30 + k), 16'(16'h20 + k), 16'(16'h10 + k), 16'(k + 1)};
      cycle(ALL, 1'b1, 1'b1, d);
      checks++;
      if (obs !== expv() || tvalid !== 1'b1 || tdata !== d || tlast !== (k == 3)) begin
        errors++;
        $display("FAIL basic_beat%0d got %h exp %h", k + 1, obs, expv());
      end
      if (k == 0) begin
        checks++;
        if (tdata !== 64'h0030_0020_0010_0001) begin
          errors++;
          $display("FAIL basic_first got %h exp 0030002000100001", tdata);
        end
      end
    end
    cycle(4'h0, 1'b1, 1'b1, '0);
    checks++;
    if (tvalid !== 1'b0 || obs !== expv()) begin
      errors++;
      $display("FAIL basic_drain got %h exp %h", obs, expv());
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(ALL, 1'b1, 1'b0, rnd64());
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL ovf_fill i=%0d got %h exp %h", i, obs, expv());
      end
    end
    checks++;
    if (level !== 5'd16 || ovf_cnt !== 4'd4) begin
      errors++;
      $display("FAIL ovf_count got level %0d cnt %0d exp level 16 cnt 4", level, ovf_cnt);
    end
    for (int i = 1; i <= 16; i++) begin
      checks++;
      if (tvalid !== 1'b1 || tlast !== (i % 4 == 0) || obs !== expv()) begin
        errors++;
        $display("FAIL ovf_drain beat=%0d got %h exp %h", i, obs, expv());
      end
      cycle(4'h0, 1'b1, 1'b1, '0);
    end
    checks++;
    if (tvalid !== 1'b0 || level !== 5'd0) begin
      errors++;
      $display("FAIL ovf_empty got valid %b level %0d exp 0 0", tvalid, level);
    end
    for (int i = 0; i < 16; i++) cycle(ALL, 1'b1, 1'b0, rnd64());
    cycle(ALL, 1'b1, 1'b1, rnd64());
    checks++;
    if (level !== 5'd16 || ovf_cnt !== 4'd4 || obs !== expv()) begin
      errors++;
      $display("FAIL full_pop got level %0d cnt %0d exp level 16 cnt 4", level, ovf_cnt);
    end
    for (int i = 0; i < 15; i++) cycle(ALL, 1'b1, 1'b0, rnd64());
    checks++;
    if (ovf_cnt !== 4'd15 || obs !== expv()) begin
      errors++;
      $display("FAIL ovf_saturate got %0d exp 15", ovf_cnt);
    end
  endtask

  task automatic test_enable_drop();
    int seen;
    seen = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(ALL, i < 2, 1'b1, rnd64());
      if (tvalid) seen++;
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL en_drop i=%0d got %h exp %h", i, obs, expv());
      end
      if (i == 3) begin
        checks++;
        if (tlast !== 1'b1 || active !== 1'b0) begin
          errors++;
          $display("FAIL en_drop_last got tlast %b active %b exp 1 0", tlast, active);
        end
      end
    end
    checks++;
    if (seen != 4 || ovf_cnt !== '0 || active !== 1'b0) begin
      errors++;
      $display("FAIL en_drop_end got beats %0d cnt %0d active %b exp 4 0 0", seen, ovf_cnt, active);
    end
  endtask

  task automatic test_partial();
    logic [3:0] pats [7];
    pats = '{4'b0011, 4'b0011, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0111};
    do_reset();
    for (int i = 0; i < 3; i++) cycle(ALL, 1'b1, 1'b0, rnd64());
    foreach (pats[i]) begin
      cycle(pats[i], 1'b1, 1'b0, rnd64());
      checks++;
      if (level !== 5'd3 || ovf_cnt !== '0 || obs !== expv()) begin
        errors++;
        $display("FAIL partial i=%0d got level %0d cnt %0d exp 3 0", i, level, ovf_cnt);
      end
    end
    for (int i = 0; i < 13; i++) cycle(ALL, 1'b1, 1'b0, rnd64());
    foreach (pats[i]) cycle(pats[i], 1'b1, 1'b0, rnd64());
    checks++;
    if (level !== 5'd16 || ovf_cnt !== '0 || obs !== expv()) begin
      errors++;
      $display("FAIL partial_full got level %0d cnt %0d exp 16 0", level, ovf_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic en;
    logic [3:0] v;
    logic rdy;
    en = 1'b1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) en = ~en;
      v   = ($urandom_range(0, 3) != 0) ? ALL : 4'($urandom);
      rdy = ((i / 200) % 2 == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      cycle(v, en, rdy, rnd64());
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL random i=%0d got %h exp %h", i, obs, expv());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {i0_v, q0_v, i1_v, q1_v} = '0;
    {i0_d, q0_d, i1_d, q1_d} = '0;
    enable = 1'b0;
    tready = 1'b0;
    model_clear();
    #2;
    test_reset();
    test_basic();
    test_overflow();
    test_enable_drop();
    test_partial();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
